// File: rtl/fetch_unit_if.sv
// Bus bundle between the fetch stage, instruction memory and the decoder.
// master = fetch unit side, slave = memory/decoder/redirect source side.
interface fetch_unit_if #(
  parameter int XLEN = 32
) ();
  logic            imem_req_o;
  logic [XLEN-1:0] imem_addr_o;
  logic            imem_gnt_i;
  logic            imem_rvalid_i;
  logic [XLEN-1:0] imem_rdata_i;
  logic            redirect_i;
  logic [XLEN-1:0] redirect_pc_i;
  logic            instr_valid_o;
  logic            instr_ready_i;
  logic [XLEN-1:0] instr_o;
  logic [XLEN-1:0] instr_pc_o;
  logic [6:0]      opcode_o;

  modport master (
    output imem_req_o,
    output imem_addr_o,
    input  imem_gnt_i,
    input  imem_rvalid_i,
    input  imem_rdata_i,
    input  redirect_i,
    input  redirect_pc_i,
    output instr_valid_o,
    input  instr_ready_i,
    output instr_o,
    output instr_pc_o,
    output opcode_o
  );

  modport slave (
    input  imem_req_o,
    input  imem_addr_o,
    output imem_gnt_i,
    output imem_rvalid_i,
    output imem_rdata_i,
    output redirect_i,
    output redirect_pc_i,
    input  instr_valid_o,
    output instr_ready_i,
    input  instr_o,
    input  instr_pc_o,
    input  opcode_o
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, issues one word fetch at a time over
// req/gnt/rvalid, and presents instruction + PC + opcode to decode over
// valid/ready. A redirect reloads the PC and any in-flight response is
// dropped so that decode never sees an instruction from the old path.
module fetch_unit #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h0000_0013)
) (
  input logic          clk_i,
  input logic          rst_ni,
  fetch_unit_if.master bus
);

  // REQ: request out; WAIT: granted, awaiting data; HOLD: instruction
  // offered to decode; FLUSH: awaiting a stale response to throw away.
  typedef enum logic [1:0] {REQ, WAIT, HOLD, FLUSH} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_nxt;
  logic [XLEN-1:0] r_req_pc;
  logic [XLEN-1:0] w_req_pc_nxt;
  logic [XLEN-1:0] r_instr;
  logic [XLEN-1:0] w_instr_nxt;
  logic [XLEN-1:0] r_instr_pc;
  logic [XLEN-1:0] w_instr_pc_nxt;
  logic            r_valid;
  logic            w_valid_nxt;
  logic            r_req;
  logic            w_gnt;
  logic            w_redir;
  logic [XLEN-1:0] w_redir_pc;

  // A grant only counts while our request is actually on the bus; this
  // masks the first cycle after reset release, when req is still low.
  assign w_gnt      = bus.imem_gnt_i & r_req;
  assign w_redir    = bus.redirect_i;
  assign w_redir_pc = bus.redirect_pc_i & ~XLEN'(3);

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= REQ;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and next-datapath decode; redirect outranks every other event.
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_req_pc_nxt   = r_req_pc;
    w_instr_nxt    = r_instr;
    w_instr_pc_nxt = r_instr_pc;
    w_valid_nxt    = r_valid;

    case (r_state)
      REQ: begin
        if (w_redir) begin
          w_pc_nxt = w_redir_pc;
          // A fetch granted in the redirect cycle belongs to the old path.
          if (w_gnt) begin
            w_state_nxt = FLUSH;
          end
        end else if (w_gnt) begin
          w_req_pc_nxt = r_pc;
          w_pc_nxt     = r_pc + XLEN'(4);
          w_state_nxt  = WAIT;
        end
      end

      WAIT: begin
        if (w_redir) begin
          w_pc_nxt = w_redir_pc;
          // If the stale data arrives together with the redirect it is
          // simply dropped here; otherwise it must be drained in FLUSH.
          w_state_nxt = bus.imem_rvalid_i ? REQ : FLUSH;
        end else if (bus.imem_rvalid_i) begin
          w_instr_nxt    = bus.imem_rdata_i;
          w_instr_pc_nxt = r_req_pc;
          w_valid_nxt    = 1'b1;
          w_state_nxt    = HOLD;
        end
      end

      HOLD: begin
        if (w_redir) begin
          w_pc_nxt    = w_redir_pc;
          w_valid_nxt = 1'b0;
          w_instr_nxt = NOP_INSTR;
          w_state_nxt = REQ;
        end else if (bus.instr_ready_i) begin
          w_valid_nxt = 1'b0;
          w_instr_nxt = NOP_INSTR;
          w_state_nxt = REQ;
        end
      end

      FLUSH: begin
        if (w_redir) begin
          w_pc_nxt = w_redir_pc;
        end else if (bus.imem_rvalid_i) begin
          w_state_nxt = REQ;
        end
      end

      default: begin
        w_state_nxt = REQ;
      end
    endcase
  end

  // PC, request flag and decode-facing registers; request tracks the state
  // we are about to enter so imem_req_o is a clean flop output.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_pc       <= RESET_PC;
      r_req      <= 1'b0;
      r_req_pc   <= '0;
      r_instr    <= NOP_INSTR;
      r_instr_pc <= '0;
      r_valid    <= 1'b0;
    end else begin
      r_pc       <= w_pc_nxt;
      r_req      <= (w_state_nxt == REQ);
      r_req_pc   <= w_req_pc_nxt;
      r_instr    <= w_instr_nxt;
      r_instr_pc <= w_instr_pc_nxt;
      r_valid    <= w_valid_nxt;
    end
  end

  assign bus.imem_req_o    = r_req;
  assign bus.imem_addr_o   = r_pc;
  assign bus.instr_valid_o = r_valid;
  assign bus.instr_o       = r_instr;
  assign bus.instr_pc_o    = r_instr_pc;
  assign bus.opcode_o      = r_instr[6:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a memory responder grants requests and
// returns data after a programmable latency; every granted fetch that should
// reach decode is pushed into a scoreboard and popped on the valid/ready
// transfer. A second instance checks PC wrap from RESET_PC=0xFFFF_FFFC.
module tb_fetch_unit;

  logic clk = 1'b0;
  logic rst_n;
  logic rst2_n;

  always #5 clk = ~clk;

  fetch_unit_if #(.XLEN(32)) a ();
  fetch_unit_if #(.XLEN(32)) b ();

  fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000), .NOP_INSTR(32'h0000_0013)) u_dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (a.master)
  );

  fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC), .NOP_INSTR(32'h0000_0013)) u_dut_wrap (
    .clk_i  (clk),
    .rst_ni (rst2_n),
    .bus    (b.master)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mem [logic [31:0]];

  int          checks = 0;
  int          errors = 0;
  int          cyc, xfer_cnt, last_xfer_cyc, last_gap;
  int          gnt_hold, rv_lat, hold_seen, pend_cnt;
  logic        ready_val, redir_now, inject_rv, arm_en, pend;
  logic [31:0] redir_tgt, arm_addr, arm_tgt, model_pc, pend_addr;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] ad);
    if (mem.exists(ad)) return mem[ad];
    return ad ^ 32'hA5A5_0003;
  endfunction

  // One clock of stimulus; everything happens at the falling edge where
  // the DUT outputs are stable.
  task automatic step();
    logic        req_s, valid_s;
    logic [31:0] addr_s;
    exp_t        e;
    @(negedge clk);
    cyc++;
    req_s   = a.imem_req_o;
    addr_s  = a.imem_addr_o;
    valid_s = a.instr_valid_o;

    if (arm_en && req_s && addr_s == arm_addr) begin
      redir_now = 1'b1;
      redir_tgt = arm_tgt;
      arm_en    = 1'b0;
    end
    a.redirect_i    = redir_now;
    a.redirect_pc_i = redir_tgt;
    if (redir_now) exp_q.delete();

    if (req_s) check_val("one_outstanding", {31'd0, pend}, 32'd0);

    a.imem_rvalid_i = 1'b0;
    a.imem_rdata_i  = 32'h0;
    if (pend) begin
      if (pend_cnt == 0) begin
        a.imem_rvalid_i = 1'b1;
        a.imem_rdata_i  = mem_rd(pend_addr);
        pend = 1'b0;
      end else begin
        pend_cnt--;
      end
    end
    if (inject_rv) begin
      a.imem_rvalid_i = 1'b1;
      a.imem_rdata_i  = 32'hBAD0_0BAD;
    end

    a.imem_gnt_i = 1'b0;
    if (req_s) begin
      check_val("req_addr", addr_s, model_pc);
      if (gnt_hold > 0) begin
        gnt_hold--;
        hold_seen++;
      end else begin
        a.imem_gnt_i = 1'b1;
        pend      = 1'b1;
        pend_cnt  = rv_lat;
        pend_addr = addr_s;
        if (!redir_now) begin
          e.pc  = addr_s;
          e.ins = mem_rd(addr_s);
          exp_q.push_back(e);
          model_pc = model_pc + 32'd4;
        end
      end
    end
    if (redir_now) model_pc = redir_tgt & ~32'd3;

    a.instr_ready_i = ready_val;
    if (valid_s && !redir_now) begin
      check_val("req_while_valid", {31'd0, req_s}, 32'd0);
      if (exp_q.size() == 0) begin
        check_val("spurious_valid", {31'd0, valid_s}, 32'd0);
      end else begin
        check_val("instr_pc", a.instr_pc_o, exp_q[0].pc);
        check_val("instr", a.instr_o, exp_q[0].ins);
        check_val("opcode", {25'd0, a.opcode_o}, {25'd0, exp_q[0].ins[6:0]});
        if (ready_val) begin
          void'(exp_q.pop_front());
          xfer_cnt++;
          last_gap      = cyc - last_xfer_cyc;
          last_xfer_cyc = cyc;
        end
      end
    end
    redir_now = 1'b0;
    inject_rv = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n           = 1'b0;
    a.imem_gnt_i    = 1'b0;
    a.imem_rvalid_i = 1'b0;
    a.imem_rdata_i  = 32'h0;
    a.redirect_i    = 1'b0;
    a.redirect_pc_i = 32'h0;
    a.instr_ready_i = 1'b0;
    #1;
    check_val("rst_req", {31'd0, a.imem_req_o}, 32'd0);
    check_val("rst_addr", a.imem_addr_o, 32'h0);
    check_val("rst_valid", {31'd0, a.instr_valid_o}, 32'd0);
    check_val("rst_instr", a.instr_o, 32'h0000_0013);
    check_val("rst_instr_pc", a.instr_pc_o, 32'h0);
    check_val("rst_opcode", {25'd0, a.opcode_o}, 32'h13);
    exp_q.delete();
    mem.delete();
    pend = 1'b0; pend_cnt = 0; pend_addr = 32'h0;
    model_pc = 32'h0;
    xfer_cnt = 0; last_xfer_cyc = cyc; last_gap = 0;
    gnt_hold = 0; rv_lat = 0; hold_seen = 0;
    ready_val = 1'b1; redir_now = 1'b0; inject_rv = 1'b0; arm_en = 1'b0;
    redir_tgt = 32'h0; arm_addr = 32'h0; arm_tgt = 32'h0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_xfers(input int target, input int budget);
    for (int i = 0; i < budget && xfer_cnt < target; i++) step();
    check_val("xfer_count", xfer_cnt, target);
  endtask

  task automatic run_until_valid(input int budget);
    for (int i = 0; i < budget && !a.instr_valid_o; i++) step();
    check_val("valid_seen", {31'd0, a.instr_valid_o}, 32'd1);
  endtask

  task automatic run_until_pend(input int budget);
    for (int i = 0; i < budget && !pend; i++) step();
    check_val("granted", {31'd0, pend}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    rst_n = 1'b0; rst2_n = 1'b0; cyc = 0;
    b.imem_gnt_i = 1'b0; b.imem_rvalid_i = 1'b0; b.imem_rdata_i = 32'h0;
    b.redirect_i = 1'b0; b.redirect_pc_i = 32'h0; b.instr_ready_i = 1'b0;

    // Back-to-back fetches, ready tied high: one instruction every 3 cycles.
    do_reset();
    mem[32'h0] = 32'h00A0_0093;
    mem[32'h4] = 32'h0011_0113;
    mem[32'h8] = 32'h0020_8193;
    run_xfers(1, 20);
    run_xfers(2, 20);
    check_val("gap_1", last_gap, 3);
    run_xfers(3, 20);
    check_val("gap_2", last_gap, 3);

    // Grant withheld for 4 cycles: request and address must hold.
    do_reset();
    gnt_hold = 4;
    run_xfers(1, 30);
    check_val("gnt_wait_cycles", hold_seen, 4);

    // Decoder back-pressure: instruction held stable, no new request.
    do_reset();
    mem[32'h0] = 32'h00B5_0533;
    ready_val = 1'b0;
    run_until_valid(20);
    check_val("op_rtype", {25'd0, a.opcode_o}, 32'h33);
    repeat (5) step();
    check_val("held_valid", {31'd0, a.instr_valid_o}, 32'd1);
    ready_val = 1'b1;
    step();
    check_val("xfer_after_ready", xfer_cnt, 1);
    step();
    check_val("valid_drop", {31'd0, a.instr_valid_o}, 32'd0);
    check_val("req_next", {31'd0, a.imem_req_o}, 32'd1);
    check_val("addr_next", a.imem_addr_o, 32'h4);

    // Redirect while waiting for data: late response discarded.
    do_reset();
    mem[32'h0]   = 32'hDEAD_BEEF;
    mem[32'h100] = 32'h0000_0517;
    rv_lat = 3;
    run_until_pend(10);
    rv_lat = 0;
    redir_now = 1'b1; redir_tgt = 32'h0000_0103;
    step();
    run_xfers(1, 30);

    // Redirect in the same cycle as the grant for 0x8.
    do_reset();
    mem[32'h8]  = 32'hCAFE_F00D;
    mem[32'h40] = 32'h0000_006F;
    run_xfers(2, 20);
    arm_en = 1'b1; arm_addr = 32'h8; arm_tgt = 32'h40;
    run_xfers(3, 30);
    check_val("arm_fired", {31'd0, arm_en}, 32'd0);

    // Redirect while holding with ready high: no transfer.
    do_reset();
    ready_val = 1'b0;
    run_until_valid(20);
    ready_val = 1'b1; redir_now = 1'b1; redir_tgt = 32'h0000_0200;
    step();
    check_val("no_xfer_on_redirect", xfer_cnt, 0);
    step();
    check_val("valid_drop_redir", {31'd0, a.instr_valid_o}, 32'd0);
    run_xfers(1, 20);

    // Reset during WAIT, then a stray response while requesting.
    do_reset();
    rv_lat = 5;
    run_until_pend(10);
    step();
    do_reset();
    gnt_hold = 2;
    inject_rv = 1'b1;
    step();
    inject_rv = 1'b1;
    step();
    check_val("stray_valid", {31'd0, a.instr_valid_o}, 32'd0);
    check_val("stray_instr", a.instr_o, 32'h0000_0013);
    run_xfers(1, 20);

    // PC wraps from 0xFFFF_FFFC to 0.
    @(negedge clk);
    check_val("wrap_rst_addr", b.imem_addr_o, 32'hFFFF_FFFC);
    check_val("wrap_rst_req", {31'd0, b.imem_req_o}, 32'd0);
    rst2_n = 1'b1;
    @(negedge clk);
    check_val("wrap_req", {31'd0, b.imem_req_o}, 32'd1);
    check_val("wrap_addr", b.imem_addr_o, 32'hFFFF_FFFC);
    b.imem_gnt_i = 1'b1;
    @(negedge clk);
    b.imem_gnt_i = 1'b0;
    check_val("wrap_wait_req", {31'd0, b.imem_req_o}, 32'd0);
    b.imem_rvalid_i = 1'b1; b.imem_rdata_i = 32'h0010_0073;
    @(negedge clk);
    b.imem_rvalid_i = 1'b0;
    check_val("wrap_valid", {31'd0, b.instr_valid_o}, 32'd1);
    check_val("wrap_instr_pc", b.instr_pc_o, 32'hFFFF_FFFC);
    check_val("wrap_instr", b.instr_o, 32'h0010_0073);
    b.instr_ready_i = 1'b1;
    @(negedge clk);
    b.instr_ready_i = 1'b0;
    check_val("wrap_valid_drop", {31'd0, b.instr_valid_o}, 32'd0);
    check_val("wrap_next_req", {31'd0, b.imem_req_o}, 32'd1);
    check_val("wrap_next_addr", b.imem_addr_o, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage that sits directly upstream of the opcode decoder in the single-cycle RISC-V core.
- Holds the PC and issues word fetches to instruction memory over a req/gnt/rvalid handshake.
- Presents the fetched instruction, its PC and its 7-bit opcode to decode, with a valid/ready handshake.
- Supports PC redirect (branch/jump) with discard of stale in-flight responses.

Parameters:
- XLEN, 32, datapath and address width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- NOP_INSTR, 32'h0000_0013, value driven on instr_o when no valid instruction is held (addi x0,x0,0).

Ports:
- clk_i  in  1  clock; one clock; reset is asynchronous and active-low.
- rst_ni  in  1  asynchronous active-low reset.
- imem_req_o  out  1  fetch request.
- imem_addr_o  out  XLEN  fetch address, word aligned.
- imem_gnt_i  in  1  request accepted this cycle.
- imem_rvalid_i  in  1  read data valid.
- imem_rdata_i  in  XLEN  read data.
- redirect_i  in  1  load new PC.
- redirect_pc_i  in  XLEN  redirect target; bits [1:0] ignored.
- instr_valid_o  out  1  instr_o/instr_pc_o/opcode_o valid.
- instr_ready_i  in  1  decode accepts instruction.
- instr_o  out  XLEN  fetched instruction.
- instr_pc_o  out  XLEN  PC of instr_o.
- opcode_o  out  7  instr_o[6:0], for the decoder.

Behaviour:
- All outputs registered except opcode_o, which equals instr_o[6:0] combinationally.
- Reset (async, rst_ni=0):
  - state=REQ, pc_q=RESET_PC.
  - imem_req_o=0, imem_addr_o=RESET_PC.
  - instr_valid_o=0, instr_o=NOP_INSTR (opcode 0010011), instr_pc_o=0.
  - Reset asserted mid-transaction aborts immediately; no state survives.
- imem_req_o=1 only in state REQ, and not in the cycle rst_ni is low. imem_addr_o=pc_q. At most one outstanding request.
- FSM states REQ, WAIT, HOLD, FLUSH. Redirect has priority over every other event.
- REQ:
  - gnt=1: req_pc_q<=pc_q, pc_q<=pc_q+4 (mod 2^XLEN; 32'hFFFF_FFFC wraps to 0), go WAIT.
  - gnt=0: stay REQ. The address may change only on redirect.
  - redirect, gnt=0: pc_q<={redirect_pc_i[XLEN-1:2],2'b00}, stay REQ.
  - redirect, gnt=1 in the same cycle: pc_q<=redirect target, go FLUSH (the granted fetch is stale).
- WAIT:
  - rvalid=1: instr_o<=rdata, instr_pc_o<=req_pc_q, instr_valid_o<=1, go HOLD.
  - redirect with rvalid=1: discard data, pc_q<=target, go REQ.
  - redirect with rvalid=0: pc_q<=target, go FLUSH.
- HOLD (instr_valid_o=1, outputs stable):
  - instr_ready_i=1: transfer completes; instr_valid_o<=0, instr_o<=NOP_INSTR, go REQ.
  - instr_ready_i=0: hold.
  - redirect: valid dropped, no transfer even if instr_ready_i=1; pc_q<=target, go REQ.
- FLUSH:
  - rvalid=1: discard, go REQ.
  - redirect: pc_q<=target, stay FLUSH.
- imem_rvalid_i in REQ or HOLD is ignored. This covers late responses after reset.
- Best-case throughput: one instruction per 3 cycles (REQ+gnt, WAIT+rvalid, HOLD+ready).
- instr_valid_o never goes high for data belonging to a fetch issued before the most recent redirect.

Test Plan:
- Reset release, memory gnt same cycle and rvalid next cycle, ready tied 1 -> fetch addrs 0x0, 0x4, 0x8. instr_pc_o 0x0, 0x4, 0x8, with valid each 3rd cycle. Data 0x00A00093 gives opcode_o=0010011.
- gnt withheld 4 cycles -> imem_req_o held 1 with addr 0x0 stable; pc_q unchanged until gnt.
- Instruction 0x00B50533 valid, instr_ready_i=0 for 5 cycles -> outputs stable, no new req. Ready=1 -> valid drops next cycle, req to 0x4. opcode_o=0110011.
- Redirect to 0x103 asserted in WAIT before rvalid -> next rvalid (data 0xDEADBEEF) discarded, valid stays 0. Next fetch addr 0x100; delivered instr_pc_o=0x100.
- Redirect to 0x40 in the same cycle as gnt for 0x8 -> FLUSH. Response for 0x8 never appears on instr_o; next req addr 0x40.
- RESET_PC=32'hFFFF_FFFC, one fetch -> next req addr 0x0. Additionally: assert rst_ni low while in WAIT, release, then inject a stray rvalid in REQ -> ignored; instr_valid_o=0, instr_o=0x00000013.
